mux_1x8: RTL and testbench
==========================

Name: mux_1x8

Overview:
- Parameterized 8-to-1 word multiplexer used in the CLB datapath to route one of eight equal-width operands onto a shared bus.
- Provides a purely combinational output `out`, which is the primary function.
- Also provides a registered copy `out_q` with a load enable, for pipelined consumers.
- The clock and reset serve only the registered path; `out` never depends on them.

Parameters:
- WIDTH, 8, bit width of every data input and of both outputs (`out`, `out_q`); legal range >= 1.

Ports:
- clk  input  1  rising-edge clock for the registered path.
- rst_n  input  1  asynchronous, active-low reset; clears the registered path.
- in0  input  WIDTH  data input selected when sel = 3'd0.
- in1  input  WIDTH  data input selected when sel = 3'd1.
- in2  input  WIDTH  data input selected when sel = 3'd2.
- in3  input  WIDTH  data input selected when sel = 3'd3.
- in4  input  WIDTH  data input selected when sel = 3'd4.
- in5  input  WIDTH  data input selected when sel = 3'd5.
- in6  input  WIDTH  data input selected when sel = 3'd6.
- in7  input  WIDTH  data input selected when sel = 3'd7.
- sel  input  3  select index.
- en  input  1  load enable for `out_q`; active high.
- out  output  WIDTH  combinational selected word.
- out_q  output  WIDTH  registered selected word.

Behaviour:
- Interface: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Combinational path:
  - `out` = in[sel], decoded exactly: 0->in0, 1->in1, …, 7->in7.
  - Zero latency; `out` follows any change on `sel` or on the selected input within the same delta/timestep.
  - Changes on non-selected inputs have no effect on `out`.
- Undriven select: if `sel` contains X/Z bits, `out` is X in simulation. No default-to-in0 masking.
- Complete decode: all 8 codes are valid, so there are no out-of-range values and no latch inference. Implement as a full case or equivalent AND-OR tree.
- `out` is independent of `clk`, `rst_n` and `en`. It is valid even with `clk` unconnected and `rst_n` floating, so a stand-alone combinational instantiation with those ports left open must work.
- Registered path:
  - On the rising edge of `clk` with `rst_n` = 1 and `en` = 1: `out_q` <= the value `out` has just before the edge.
  - Latency is one cycle.
  - With `en` = 0, `out_q` holds its value.
- Reset:
  - `rst_n` = 0 asynchronously forces `out_q` to all-zeros immediately, regardless of `clk` and `en`.
  - While `rst_n` is low, `out_q` stays 0. The first load occurs on the first rising edge after `rst_n` returns high with `en` = 1.
  - Reset never affects `out`.
- Reset value of every output: `out_q` = {WIDTH{1'b0}}. `out` has no reset value; it is combinational.
- Width rules: no arithmetic. Inputs and outputs are all exactly WIDTH bits, with no extension or truncation.
- Sel wrap: a caller incrementing a 3-bit `sel` past 7 wraps to 0. The mux simply decodes 0 (in0); no special handling.
- Simultaneous events: a `sel` change coincident with a clock edge loads the pre-edge selection (standard non-blocking semantics).
- Asynchronous reset asserted mid-operation overrides a coincident enabled load.

Test Plan:
- WIDTH=8, in0..in7 = 8'h00,8'h11,…,8'h77, clk/rst_n unconnected, sel = 0, then sel+1 every 10 time units for 8 steps -> `out` reads 8'h00,8'h11,8'h22,8'h33,8'h44,8'h55,8'h66,8'h77, then 8'h00 after the wrap 7->0.
- Fixed sel = 3'd5 while toggling in4 and in6 -> `out` stays 8'h55. Then change in5 to 8'hA5 -> `out` = 8'hA5 with no delay.
- Registered path, rst_n = 1, en = 1, sel = 2 -> after the next rising edge `out_q` = 8'h22. Set sel = 6 -> `out` = 8'h66 immediately; `out_q` becomes 8'h66 one edge later.
- en = 0 with `out_q` = 8'h66, sel swept 0..7 over several edges -> `out_q` holds 8'h66 while `out` tracks sel.
- Assert rst_n = 0 between clock edges with `out_q` = 8'h66 -> `out_q` = 8'h00 at once; `out` is unaffected.
- Release rst_n with en = 1, sel = 7 -> `out_q` = 8'h77 only after the next rising edge.
- WIDTH=32 instance, inputs set to distinct 32-bit patterns (e.g. 32'hDEAD_0000+k) -> `out` equals the selected pattern for all 8 sel values.

Source files
------------

// File: rtl/mux_1x8.sv
// 8-to-1 word multiplexer with a combinational output and an enabled registered copy.
// Latency: out is combinational (0 cycles); out_q is loaded one clk edge after selection.
// Backpressure: none; en gates the register load, and out always follows sel and the inputs.
module mux_1x8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [WIDTH-1:0] in5,
    input  logic [WIDTH-1:0] in6,
    input  logic [WIDTH-1:0] in7,
    input  logic [2:0]       sel,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q
);

    // An unknown sel propagates X instead of silently picking in0.
    always_comb begin
        case (sel)
            3'd0:    out = in0;
            3'd1:    out = in1;
            3'd2:    out = in2;
            3'd3:    out = in3;
            3'd4:    out = in4;
            3'd5:    out = in5;
            3'd6:    out = in6;
            3'd7:    out = in7;
            default: out = {WIDTH{1'bx}};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= {WIDTH{1'b0}};
        end else if (en) begin
            out_q <= out;
        end
    end

endmodule

// File: tb/tb_mux_1x8.sv
// Directed and randomized checks of mux_1x8 at WIDTH=8 and WIDTH=32 against an array-indexing model.
module tb_mux_1x8;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_arr [8];
    logic [2:0]  sel;
    logic        en;
    logic [7:0]  out;
    logic [7:0]  out_q;

    logic        rst32_n;
    logic [31:0] w_arr [8];
    logic [2:0]  sel32;
    logic        en32;
    logic [31:0] out32;
    logic [31:0] out_q32;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q;

    mux_1x8 #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0(in_arr[0]), .in1(in_arr[1]), .in2(in_arr[2]), .in3(in_arr[3]),
        .in4(in_arr[4]), .in5(in_arr[5]), .in6(in_arr[6]), .in7(in_arr[7]),
        .sel(sel), .en(en), .out(out), .out_q(out_q)
    );

    mux_1x8 #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst32_n),
        .in0(w_arr[0]), .in1(w_arr[1]), .in2(w_arr[2]), .in3(w_arr[3]),
        .in4(w_arr[4]), .in5(w_arr[5]), .in6(w_arr[6]), .in7(w_arr[7]),
        .sel(sel32), .en(en32), .out(out32), .out_q(out_q32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rst32_n = 1'b0;
        en = 1'b0;
        en32 = 1'b0;
        sel = 3'd0;
        sel32 = 3'd0;
        for (int k = 0; k < 8; k++) begin
            in_arr[k] = 8'(k * 8'h11);
            w_arr[k]  = 32'hDEAD_0000 + 32'(k);
        end
        #2;
        check("reset_out_q", out_q, 8'h00);
        check("reset_out_q32", out_q32, 32'h0);

        // combinational sweep with wrap, registered path held in reset
        for (int s = 0; s <= 8; s++) begin
            sel = 3'(s);
            #1;
            check($sformatf("sweep_sel%0d", s), out, in_arr[s % 8]);
            #9;
        end
        check("sweep_out_q_reset", out_q, 8'h00);

        // non-selected inputs must not disturb out
        sel = 3'd5;
        for (int t = 0; t < 4; t++) begin
            in_arr[4] = 8'($urandom);
            in_arr[6] = 8'($urandom);
            #1;
            check("nonsel_toggle", out, 8'h55);
        end
        in_arr[4] = 8'h44;
        in_arr[6] = 8'h66;
        in_arr[5] = 8'hA5;
        #1;
        check("sel_input_change", out, 8'hA5);
        in_arr[5] = 8'h55;

        // registered path
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        sel = 3'd2;
        #1;
        check("preload_out_q", out_q, 8'h00);
        @(posedge clk); #1;
        check("load_22", out_q, 8'h22);
        @(negedge clk);
        sel = 3'd6;
        #1;
        check("out_66_now", out, 8'h66);
        check("out_q_still_22", out_q, 8'h22);
        @(posedge clk); #1;
        check("load_66", out_q, 8'h66);

        // hold with en low
        @(negedge clk);
        en = 1'b0;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            #1;
            check("hold_out_tracks", out, in_arr[s]);
            @(posedge clk); #1;
            check("hold_out_q", out_q, 8'h66);
            @(negedge clk);
        end

        // asynchronous reset between edges
        sel = 3'd3;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_q", out_q, 8'h00);
        check("async_rst_out", out, 8'h33);

        // release with en=1, sel=7: load waits for the next edge
        @(negedge clk);
        en = 1'b1;
        sel = 3'd7;
        rst_n = 1'b1;
        #1;
        check("release_no_load", out_q, 8'h00);
        @(posedge clk); #1;
        check("release_load_77", out_q, 8'h77);

        // randomized run against the model
        exp_q = out_q;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++) in_arr[k] = 8'($urandom);
            sel = 3'($urandom_range(0, 7));
            en = 1'($urandom_range(0, 1));
            rst_n = ($urandom_range(0, 15) != 0);
            if (!rst_n) exp_q = 8'h00;
            #1;
            check("rand_out", out, in_arr[sel]);
            check("rand_out_q_pre", out_q, exp_q);
            @(posedge clk);
            if (rst_n && en) exp_q = in_arr[sel];
            #1;
            check("rand_out_q", out_q, exp_q);
        end

        // WIDTH=32 instance
        for (int s = 0; s < 8; s++) begin
            sel32 = 3'(s);
            #1;
            check($sformatf("w32_sel%0d", s), out32, 32'hDEAD_0000 + 32'(s));
        end
        for (int c = 0; c < 20; c++) begin
            for (int k = 0; k < 8; k++) w_arr[k] = $urandom;
            sel32 = 3'($urandom_range(0, 7));
            #1;
            check("w32_rand", out32, w_arr[sel32]);
        end
        @(negedge clk);
        rst32_n = 1'b1;
        en32 = 1'b1;
        sel32 = 3'd4;
        @(posedge clk); #1;
        check("w32_load", out_q32, w_arr[4]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
